// File: rtl/emmc_cmd_engine.sv
// eMMC CMD-line engine: divides mclk into the card clock, sends 48-bit commands with CRC7,
// receives R48/R136 responses with CRC/index/end-bit checks and NCR timeout, then holds an NCC gap.
module emmc_cmd_engine #(
   parameter int CLK_DIV = 2,
   parameter int NCR_MAX = 64,
   parameter int NCC_GAP = 8
) (
   input  logic         mclk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_arg,
   input  logic [1:0]   resp_type,
   output logic         resp_valid,
   output logic [135:0] resp_data,
   output logic         resp_timeout,
   output logic         resp_crc_err,
   output logic         resp_idx_err,
   output logic         busy,
   output logic         o_clk,
   output logic         cmd_o,
   output logic         cmd_oe,
   input  logic         cmd_i
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int NCR_W = $clog2(NCR_MAX);
   localparam int GAP_W = (NCC_GAP > 1) ? $clog2(NCC_GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT, S_RECV, S_CHECK, S_GAP
   } state_t;

   state_t r_state, w_next;

   logic [DIV_W-1:0] r_div;
   logic             r_clk;
   logic [7:0]       r_bit;
   logic [NCR_W-1:0] r_ncr;
   logic [GAP_W-1:0] r_gap;
   logic [47:0]      r_tx;
   logic [135:0]     r_rx;
   logic [5:0]       r_idx;
   logic [1:0]       r_type;
   logic             r_cmd_o;
   logic             r_cmd_oe;
   logic             r_resp_valid;
   logic [135:0]     r_resp_data;
   logic             r_timeout;
   logic             r_crc_err;
   logic             r_idx_err;

   logic             w_tick;
   logic             w_fall;
   logic             w_rise;
   logic [7:0]       w_rx_len;
   logic             w_ncr_end;
   logic             w_gap_end;
   logic [39:0]      w_payload;
   logic [6:0]       w_tx_crc;
   logic [6:0]       w_rx_crc;
   logic             w_crc_err;
   logic             w_idx_err;

   // Serial CRC7 (x^7+x^3+1, init 0); leading zero bits leave a zero state untouched,
   // so shorter fields are simply zero-extended on the left.
   function automatic logic [6:0] f_crc7(input logic [119:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 119; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign w_tick    = (r_div == DIV_W'(CLK_DIV - 1));
   assign w_fall    = w_tick & r_clk;
   assign w_rise    = w_tick & ~r_clk;
   assign w_rx_len  = (r_type == 2'b10) ? 8'd136 : 8'd48;
   assign w_ncr_end = (r_ncr == NCR_W'(NCR_MAX - 1));
   assign w_gap_end = (r_gap == GAP_W'(NCC_GAP - 1));
   assign w_payload = {2'b01, cmd_index, cmd_arg};
   assign w_tx_crc  = f_crc7({80'b0, w_payload});
   assign w_rx_crc  = f_crc7((r_type == 2'b10) ? r_rx[127:8] : {80'b0, r_rx[47:8]});
   assign w_crc_err = (r_type == 2'b11) ? ~r_rx[0] : ((w_rx_crc != r_rx[7:1]) | ~r_rx[0]);
   assign w_idx_err = (r_type == 2'b01) && (r_rx[45:40] != r_idx);

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
         r_clk <= 1'b0;
      end else if (w_tick) begin
         r_div <= '0;
         r_clk <= ~r_clk;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (cmd_valid) w_next = S_SEND;
         S_SEND:  if (w_fall && r_bit == 8'd48) w_next = (r_type == 2'b00) ? S_GAP : S_WAIT;
         S_WAIT: begin
            // A start bit seen on the terminal rise wins over the timeout.
            if (w_rise) begin
               if (!cmd_i)         w_next = S_RECV;
               else if (w_ncr_end) w_next = S_GAP;
            end
         end
         S_RECV:  if (w_rise && r_bit == w_rx_len - 8'd1) w_next = S_CHECK;
         S_CHECK: w_next = S_GAP;
         S_GAP:   if (w_rise && w_gap_end) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         r_bit        <= '0;
         r_ncr        <= '0;
         r_gap        <= '0;
         r_tx         <= '0;
         r_rx         <= '0;
         r_idx        <= '0;
         r_type       <= '0;
         r_cmd_o      <= 1'b1;
         r_cmd_oe     <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_timeout    <= 1'b0;
         r_crc_err    <= 1'b0;
         r_idx_err    <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_tx   <= {w_payload, w_tx_crc, 1'b1};
                  r_idx  <= cmd_index;
                  r_type <= resp_type;
                  r_bit  <= '0;
               end
            end
            S_SEND: begin
               if (w_fall) begin
                  if (r_bit == 8'd48) begin
                     r_cmd_oe <= 1'b0;
                     r_cmd_o  <= 1'b1;
                     r_ncr    <= '0;
                     r_gap    <= '0;
                     if (r_type == 2'b00) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= '0;
                        r_timeout    <= 1'b0;
                        r_crc_err    <= 1'b0;
                        r_idx_err    <= 1'b0;
                     end
                  end else begin
                     r_cmd_oe <= 1'b1;
                     r_cmd_o  <= r_tx[47];
                     r_tx     <= {r_tx[46:0], 1'b0};
                     r_bit    <= r_bit + 8'd1;
                  end
               end
            end
            S_WAIT: begin
               if (w_rise) begin
                  if (!cmd_i) begin
                     r_rx  <= '0;
                     r_bit <= 8'd1;
                  end else if (w_ncr_end) begin
                     r_resp_valid <= 1'b1;
                     r_timeout    <= 1'b1;
                     r_crc_err    <= 1'b0;
                     r_idx_err    <= 1'b0;
                  end else begin
                     r_ncr <= r_ncr + NCR_W'(1);
                  end
               end
            end
            S_RECV: begin
               if (w_rise) begin
                  r_rx  <= {r_rx[134:0], cmd_i};
                  r_bit <= r_bit + 8'd1;
               end
            end
            S_CHECK: begin
               r_resp_valid <= 1'b1;
               r_resp_data  <= (r_type == 2'b10) ? r_rx : {88'b0, r_rx[47:0]};
               r_timeout    <= 1'b0;
               r_crc_err    <= w_crc_err;
               r_idx_err    <= w_idx_err;
            end
            S_GAP: begin
               if (w_rise && !w_gap_end) r_gap <= r_gap + GAP_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready    = (r_state == S_IDLE);
   assign busy         = ~cmd_ready;
   assign o_clk        = r_clk;
   assign cmd_o        = r_cmd_o;
   assign cmd_oe       = r_cmd_oe;
   assign resp_valid   = r_resp_valid;
   assign resp_data    = r_resp_data;
   assign resp_timeout = r_timeout;
   assign resp_crc_err = r_crc_err;
   assign resp_idx_err = r_idx_err;

endmodule

// File: tb/tb_emmc_cmd_engine.sv
// Bench for emmc_cmd_engine: three instances (CLK_DIV 2, 1, 5) driven by directed steps,
// with a card model on the CMD line and a queue of expected transaction results.
module tb_emmc_cmd_engine;
   localparam int N = 3;

   logic         mclk = 1'b0;
   logic         rst;
   logic         cmd_valid [N];
   logic         cmd_ready [N];
   logic [5:0]   cmd_index [N];
   logic [31:0]  cmd_arg [N];
   logic [1:0]   resp_type [N];
   logic         resp_valid [N];
   logic [135:0] resp_data [N];
   logic         resp_timeout [N];
   logic         resp_crc_err [N];
   logic         resp_idx_err [N];
   logic         busy [N];
   logic         o_clk [N];
   logic         cmd_o [N];
   logic         cmd_oe [N];
   logic         cmd_i [N];

   always #5 mclk = ~mclk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      emmc_cmd_engine #(
         .CLK_DIV ((g == 0) ? 2 : ((g == 1) ? 1 : 5)),
         .NCR_MAX (64),
         .NCC_GAP (8)
      ) u_dut (
         .mclk         (mclk),
         .rst          (rst),
         .cmd_valid    (cmd_valid[g]),
         .cmd_ready    (cmd_ready[g]),
         .cmd_index    (cmd_index[g]),
         .cmd_arg      (cmd_arg[g]),
         .resp_type    (resp_type[g]),
         .resp_valid   (resp_valid[g]),
         .resp_data    (resp_data[g]),
         .resp_timeout (resp_timeout[g]),
         .resp_crc_err (resp_crc_err[g]),
         .resp_idx_err (resp_idx_err[g]),
         .busy         (busy[g]),
         .o_clk        (o_clk[g]),
         .cmd_o        (cmd_o[g]),
         .cmd_oe       (cmd_oe[g]),
         .cmd_i        (cmd_i[g])
      );
   end

   typedef struct {
      logic [47:0]  frame;
      logic [135:0] data;
      logic         to;
      logic         crc;
      logic         idx;
   } exp_t;

   exp_t         sb [$];
   logic [135:0] last_data [N];
   int           total = 0;
   int           bad = 0;

   // CRC7 as the remainder of d*x^7 divided by x^7+x^3+1.
   function automatic logic [6:0] f_crc(input logic [119:0] d);
      logic [126:0] r;
      r = {d, 7'b0};
      for (int i = 126; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] f_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] p;
      p = {2'b01, idx, arg};
      return {p, f_crc({80'b0, p}), 1'b1};
   endfunction

   function automatic logic [135:0] mk_r48(input logic [7:0] hi, input logic [31:0] arg,
                                           input logic [6:0] crc_xor, input logic eb);
      logic [39:0] p;
      p = {hi, arg};
      return {88'b0, p, f_crc({80'b0, p}) ^ crc_xor, eb};
   endfunction

   function automatic logic [135:0] mk_r136(input logic [119:0] cid);
      return {8'h3F, cid, f_crc(cid), 1'b1};
   endfunction

   task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction on instance k; the card starts its reply so that the start
   // bit is sampled on the d-th rising card clock after the command frame ends.
   task automatic run_txn(input int k, input string nm, input logic [5:0] idx,
                          input logic [31:0] arg, input logic [1:0] rt,
                          input logic [135:0] rsp, input int rlen, input int d, input bit hold,
                          input bit e_to, input bit e_crc, input bit e_idx,
                          output logic [47:0] got);
      exp_t e;
      exp_t o;
      int   oe_n, pulses, gap, rw, fidx, sent;
      bit   seen_oe, dropped, rv, done, rise, fall, drv;
      logic pclk;
      string t;
      t = $sformatf("k%0d %s", k, nm);
      e.frame = f_frame(idx, arg);
      if (rt == 2'b00)    e.data = '0;
      else if (rlen == 0) e.data = last_data[k];
      else if (rlen == 48) e.data = {88'b0, rsp[47:0]};
      else                e.data = rsp;
      e.to = e_to; e.crc = e_crc; e.idx = e_idx;
      sb.push_back(e);
      last_data[k] = e.data;
      oe_n = 0; pulses = 0; gap = 0; rw = 0; fidx = 0; sent = 0;
      seen_oe = 0; dropped = 0; rv = 0; done = 0;
      got = '0;
      cmd_i[k] = 1'b1;
      cmd_index[k] = idx; cmd_arg[k] = arg; resp_type[k] = rt; cmd_valid[k] = 1'b1;
      @(negedge mclk);
      chk({t, " busy"}, {135'b0, busy[k]}, 136'd1);
      if (hold) begin
         cmd_index[k] = idx ^ 6'h2A;
         cmd_arg[k]   = ~arg;
      end else begin
         cmd_valid[k] = 1'b0;
      end
      pclk = o_clk[k];
      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
         @(negedge mclk);
         rise = o_clk[k] & ~pclk;
         fall = ~o_clk[k] & pclk;
         pclk = o_clk[k];
         drv  = 0;
         if (!dropped) begin
            if (rise && cmd_oe[k]) begin
               got = {got[46:0], cmd_o[k]};
               oe_n++;
            end
            if (cmd_oe[k]) seen_oe = 1;
            else if (seen_oe) begin
               dropped = 1;
               drv = 1;
               chk({t, " idle_hi"}, {135'b0, cmd_o[k]}, 136'd1);
            end
         end else begin
            if (fall) begin fidx++; drv = 1; end
            if (rise && !rv) rw++;
         end
         if (drv && rlen > 0) begin
            if (fidx >= d - 1 && sent < rlen) begin
               cmd_i[k] = rsp[rlen - 1 - sent];
               sent++;
            end else begin
               cmd_i[k] = 1'b1;
            end
         end
         if (rv && rise) gap++;
         if (resp_valid[k]) begin
            pulses++;
            if (!rv) begin
               rv = 1;
               if (hold) cmd_valid[k] = 1'b0;
               o = sb.pop_front();
               chk({t, " frame"}, {88'b0, got}, {88'b0, o.frame});
               chk({t, " oe_periods"}, 136'(oe_n), 136'd48);
               chk({t, " data"}, resp_data[k], o.data);
               chk({t, " timeout"}, {135'b0, resp_timeout[k]}, {135'b0, o.to});
               chk({t, " crc_err"}, {135'b0, resp_crc_err[k]}, {135'b0, o.crc});
               chk({t, " idx_err"}, {135'b0, resp_idx_err[k]}, {135'b0, o.idx});
               if (o.to) chk({t, " ncr_rises"}, 136'(rw), 136'd64);
            end
         end
         if (rv && cmd_ready[k]) done = 1;
      end
      cmd_valid[k] = 1'b0;
      cmd_i[k] = 1'b1;
      chk({t, " completed"}, {135'b0, done}, 136'd1);
      chk({t, " valid_pulses"}, 136'(pulses), 136'd1);
      chk({t, " ncc_gap"}, 136'(gap), 136'd8);
   endtask

   logic [47:0]  fr;
   logic [135:0] r_ok;
   logic [135:0] r_cid;
   int           n;
   int           pulses;
   logic         pclk;

   initial begin
      rst = 1'b1;
      for (int k = 0; k < N; k++) begin
         cmd_valid[k] = 1'b0; cmd_index[k] = '0; cmd_arg[k] = '0;
         resp_type[k] = '0; cmd_i[k] = 1'b1; last_data[k] = '0;
      end
      r_ok  = mk_r48(8'h11, 32'h0000_0900, 7'h00, 1'b1);
      r_cid = mk_r136(120'h15_0100_4D4D_4331_3647_0112_3456_78A9);
      repeat (3) @(negedge mclk);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("k%0d rst o_clk", k), {135'b0, o_clk[k]}, 136'd0);
         chk($sformatf("k%0d rst cmd_oe", k), {135'b0, cmd_oe[k]}, 136'd0);
         chk($sformatf("k%0d rst cmd_o", k), {135'b0, cmd_o[k]}, 136'd1);
         chk($sformatf("k%0d rst cmd_ready", k), {135'b0, cmd_ready[k]}, 136'd1);
         chk($sformatf("k%0d rst busy", k), {135'b0, busy[k]}, 136'd0);
         chk($sformatf("k%0d rst resp_valid", k), {135'b0, resp_valid[k]}, 136'd0);
         chk($sformatf("k%0d rst resp_data", k), resp_data[k], 136'd0);
         chk($sformatf("k%0d rst flags", k),
             {133'b0, resp_timeout[k], resp_crc_err[k], resp_idx_err[k]}, 136'd0);
      end
      rst = 1'b0;
      @(negedge mclk);

      run_txn(0, "t1_cmd0", 6'd0, 32'h0, 2'b00, '0, 0, 1, 0, 0, 0, 0, fr);
      chk("k0 t1 frame_literal", {88'b0, fr}, {88'b0, 48'h4000_0000_0095});
      run_txn(0, "t2_cmd17", 6'd17, 32'h0, 2'b01, r_ok, 48, 5, 0, 0, 0, 0, fr);
      chk("k0 t2 frame_literal", {88'b0, fr}, {88'b0, 48'h5100_0000_0055});
      run_txn(0, "t3_crcflip", 6'd17, 32'h0, 2'b01, mk_r48(8'h11, 32'h0000_0900, 7'h04, 1'b1),
              48, 5, 0, 0, 1, 0, fr);
      run_txn(0, "t3_badidx", 6'd17, 32'h0, 2'b01, mk_r48(8'h12, 32'h0000_0900, 7'h00, 1'b1),
              48, 7, 0, 0, 0, 1, fr);
      run_txn(0, "t3_r3_end0", 6'd1, 32'h40FF_8000, 2'b11, {88'b0, 8'h3F, 32'h00FF_8080, 8'hFE},
              48, 3, 0, 0, 1, 0, fr);
      run_txn(0, "t3_r3_ok", 6'd1, 32'h40FF_8000, 2'b11, {88'b0, 8'h3F, 32'h00FF_8080, 8'hFF},
              48, 4, 0, 0, 0, 0, fr);
      run_txn(0, "t4_cid", 6'd2, 32'h0, 2'b10, r_cid, 136, 6, 0, 0, 0, 0, fr);
      run_txn(0, "t4_timeout", 6'd2, 32'h0, 2'b10, '0, 0, 1, 0, 1, 0, 0, fr);
      run_txn(0, "t5_hold_late", 6'd17, 32'h0000_0200, 2'b01, r_ok, 48, 64, 1, 0, 0, 0, fr);
      run_txn(0, "t5_type00_clears", 6'd7, 32'h1234_0000, 2'b00, '0, 0, 1, 0, 0, 0, 0, fr);

      // Abort mid-frame with reset.
      cmd_index[0] = 6'd17; cmd_arg[0] = 32'h0; resp_type[0] = 2'b01; cmd_valid[0] = 1'b1;
      @(negedge mclk);
      cmd_valid[0] = 1'b0;
      n = 0;
      pclk = o_clk[0];
      for (int cyc = 0; cyc < 5000 && n < 20; cyc++) begin
         @(negedge mclk);
         if (o_clk[0] && !pclk && cmd_oe[0]) n++;
         pclk = o_clk[0];
      end
      chk("k0 t6 reached_bit20", 136'(n), 136'd20);
      rst = 1'b1;
      #1;
      chk("k0 t6 oe_released", {135'b0, cmd_oe[0]}, 136'd0);
      chk("k0 t6 ready", {135'b0, cmd_ready[0]}, 136'd1);
      repeat (3) @(negedge mclk);
      rst = 1'b0;
      for (int k = 0; k < N; k++) last_data[k] = '0;
      pulses = 0;
      repeat (400) begin
         @(negedge mclk);
         if (resp_valid[0]) pulses++;
      end
      chk("k0 t6 no_resp_valid", 136'(pulses), 136'd0);
      chk("k0 t6 line_idle", {134'b0, cmd_oe[0], cmd_o[0]}, 136'd1);
      run_txn(0, "t6_after_rst", 6'd17, 32'h0, 2'b01, r_ok, 48, 5, 0, 0, 0, 0, fr);
      chk("k0 t6 frame_literal", {88'b0, fr}, {88'b0, 48'h5100_0000_0055});

      for (int k = 1; k < N; k++) begin
         run_txn(k, "t1_cmd0", 6'd0, 32'h0, 2'b00, '0, 0, 1, 0, 0, 0, 0, fr);
         chk($sformatf("k%0d t1 frame_literal", k), {88'b0, fr}, {88'b0, 48'h4000_0000_0095});
         run_txn(k, "t2_cmd17", 6'd17, 32'h0, 2'b01, r_ok, 48, 5, 0, 0, 0, 0, fr);
         chk($sformatf("k%0d t2 frame_literal", k), {88'b0, fr}, {88'b0, 48'h5100_0000_0055});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
